// File: rtl/chunk_moments.sv
// chunk_moments: streams one chunk of profile samples from the sample memory
// and accumulates the regression moments n, Sx, Sy, Sxx, Sxy, Syy, where x is
// the local index inside the chunk. One descriptor is in flight at a time.
module chunk_moments #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned SW      = 64,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          desc_valid,
  output logic          desc_ready,
  input  logic [AW-1:0] si_in,
  input  logic [AW-1:0] ei_in,
  input  logic [31:0]   id_in,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   id_out,
  output logic [AW-1:0] n_out,
  output logic [SW-1:0] sum_x,
  output logic [SW-1:0] sum_y,
  output logic [SW-1:0] sum_xx,
  output logic [SW-1:0] sum_xy,
  output logic [SW-1:0] sum_yy,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] ei_q;
  logic [AW-1:0] k_q;
  logic [AW-1:0] n_q;
  logic [31:0]   id_q;
  logic          err_q;
  logic          rd_pend_q;
  logic [SW-1:0] sx_q, sy_q, sxx_q, sxy_q, syy_q;

  logic          accept;
  logic          bad_desc;
  logic          last_issue;
  logic [SW-1:0] x_w, y_w;

  // Descriptor validation and per-sample operand widening.
  always_comb begin
    accept     = 1'b0;
    bad_desc   = 1'b0;
    last_issue = 1'b0;
    x_w        = SW'(k_q);
    y_w        = SW'(rd_data);
    accept     = (state_q == S_IDLE) && desc_valid;
    // Length is checked as ei-si >= MAX_LEN so that ei-si+1 never overflows AW.
    bad_desc   = (ei_in < si_in) || ((ei_in - si_in) >= AW'(MAX_LEN));
    last_issue = (addr_q == ei_q);
  end

  // Next-state logic and state-decoded handshake/strobe outputs.
  always_comb begin
    state_d    = state_q;
    desc_ready = 1'b0;
    rd_en      = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gated by Rst so the queue is never popped while held in reset.
        desc_ready = Rst;
        if (desc_valid) begin
          state_d = bad_desc ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en = 1'b1;
        if (last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Descriptor latch, read address walk and read-return tracking.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      addr_q    <= '0;
      ei_q      <= '0;
      id_q      <= '0;
      n_q       <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= (state_q == S_FETCH);
      if (accept) begin
        id_q   <= id_in;
        ei_q   <= ei_in;
        addr_q <= si_in;
        if (bad_desc) begin
          err_q <= 1'b1;
          n_q   <= '0;
        end else begin
          err_q <= 1'b0;
          n_q   <= ei_in - si_in + AW'(1);
        end
      end else if (state_q == S_FETCH && !last_issue) begin
        // Address stops at ei so it can never wrap past the top of memory.
        addr_q <= addr_q + AW'(1);
      end
    end
  end

  // Moment accumulation on each edge that follows a read strobe.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      k_q   <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      sxx_q <= '0;
      sxy_q <= '0;
      syy_q <= '0;
    end else if (accept) begin
      k_q   <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      sxx_q <= '0;
      sxy_q <= '0;
      syy_q <= '0;
    end else if (rd_pend_q) begin
      k_q   <= k_q + AW'(1);
      sx_q  <= sx_q + x_w;
      sy_q  <= sy_q + y_w;
      sxx_q <= sxx_q + x_w * x_w;
      sxy_q <= sxy_q + x_w * y_w;
      syy_q <= syy_q + y_w * y_w;
    end
  end

  assign rd_addr = addr_q;
  assign id_out  = id_q;
  assign n_out   = n_q;
  assign err     = err_q;
  assign sum_x   = sx_q;
  assign sum_y   = sy_q;
  assign sum_xx  = sxx_q;
  assign sum_xy  = sxy_q;
  assign sum_yy  = syy_q;

endmodule

// File: tb/tb_chunk_moments.sv
// Directed bench for chunk_moments with a one-cycle-latency sample memory model.
module tb_chunk_moments;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] si_in, ei_in, id_in;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] id_out;
  logic [31:0] n_out;
  logic [63:0] sum_x, sum_y, sum_xx, sum_xy, sum_yy;
  logic        err;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          rd_cnt   = 0;
  int          lat;
  logic [31:0] addr_log[$];
  logic [31:0] mem[16];

  chunk_moments #(
    .DW(32), .AW(32), .SW(64), .MAX_LEN(8)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .si_in(si_in), .ei_in(ei_in), .id_in(id_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .id_out(id_out), .n_out(n_out),
    .sum_x(sum_x), .sum_y(sum_y), .sum_xx(sum_xx), .sum_xy(sum_xy), .sum_yy(sum_yy),
    .err(err)
  );

  always #5 Clk = ~Clk;

  // Sample memory: data one cycle after rd_en, junk on all other cycles.
  always @(posedge Clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr[3:0]];
      addr_log.push_back(rd_addr);
      rd_cnt = rd_cnt + 1;
    end else begin
      rd_data <= $urandom;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_desc(input logic [31:0] si, input logic [31:0] ei, input logic [31:0] id,
                          output int latency);
    int g;
    si_in = si; ei_in = ei; id_in = id; desc_valid = 1'b1;
    g = 0;
    while (!desc_ready && g < 50) begin
      @(posedge Clk); #1; g++;
    end
    if (g >= 50) chk("desc_ready_timeout", 64'(desc_ready), 64'd1);
    @(posedge Clk); #1;
    desc_valid = 1'b0;
    latency = 1;
    while (!res_valid && latency < 200) begin
      @(posedge Clk); #1; latency++;
    end
  endtask

  task automatic expect_res(input string t, input logic [31:0] id, input logic [31:0] n,
                            input logic [63:0] sx, input logic [63:0] sy, input logic [63:0] sxx,
                            input logic [63:0] sxy, input logic [63:0] syy, input logic e);
    chk({t, ".valid"}, 64'(res_valid), 64'd1);
    chk({t, ".id"},    64'(id_out), 64'(id));
    chk({t, ".n"},     64'(n_out), 64'(n));
    chk({t, ".sx"},    sum_x, sx);
    chk({t, ".sy"},    sum_y, sy);
    chk({t, ".sxx"},   sum_xx, sxx);
    chk({t, ".sxy"},   sum_xy, sxy);
    chk({t, ".syy"},   sum_yy, syy);
    chk({t, ".err"},   64'(err), 64'(e));
  endtask

  task automatic consume(input string t);
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
    chk({t, ".idle_ready"}, 64'(desc_ready), 64'd1);
    chk({t, ".idle_valid"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    Rst = 1'b0; desc_valid = 1'b0; res_ready = 1'b0;
    si_in = '0; ei_in = '0; id_in = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD0000 + 32'(i);
    mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
    mem[4] = 3;  mem[5] = 7;  mem[6] = 0;  mem[7] = 1;

    // Reset state
    #3;
    chk("rst.desc_ready", 64'(desc_ready), 64'd0);
    chk("rst.res_valid",  64'(res_valid), 64'd0);
    chk("rst.rd_en",      64'(rd_en), 64'd0);
    chk("rst.n_out",      64'(n_out), 64'd0);
    chk("rst.sum_yy",     sum_yy, 64'd0);
    #9 Rst = 1'b1;
    @(posedge Clk); #1;

    // Basic chunk 0..3
    addr_log.delete();
    run_desc(0, 3, 7, lat);
    chk("t1.latency", 64'(lat), 64'd6);
    expect_res("t1", 7, 4, 6, 100, 14, 200, 3000, 1'b0);
    chk("t1.nreads", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("t1.rd_addr", 64'(addr_log[i]), 64'(i));
    consume("t1");

    // Single sample, res_ready already high before DONE
    res_ready = 1'b1;
    run_desc(5, 5, 9, lat);
    chk("t2.latency", 64'(lat), 64'd3);
    expect_res("t2", 9, 1, 0, 7, 0, 0, 49, 1'b0);
    @(posedge Clk); #1;
    res_ready = 1'b0;
    chk("t2.idle_valid", 64'(res_valid), 64'd0);
    chk("t2.idle_ready", 64'(desc_ready), 64'd1);

    // Rejected: ei < si
    rd_cnt = 0;
    run_desc(9, 4, 3, lat);
    chk("t3.latency", 64'(lat), 64'd1);
    expect_res("t3", 3, 0, 0, 0, 0, 0, 0, 1'b1);
    consume("t3");
    chk("t3.no_reads", 64'(rd_cnt), 64'd0);

    // Length limit (MAX_LEN=8): 9 samples rejected, 8 accepted
    rd_cnt = 0;
    run_desc(0, 8, 4, lat);
    chk("t4.latency", 64'(lat), 64'd1);
    expect_res("t4", 4, 0, 0, 0, 0, 0, 0, 1'b1);
    consume("t4");
    chk("t4.no_reads", 64'(rd_cnt), 64'd0);
    run_desc(0, 7, 5, lat);
    chk("t5.latency", 64'(lat), 64'd10);
    expect_res("t5", 5, 8, 28, 111, 140, 254, 3059, 1'b0);
    consume("t5");

    // Consumer stall: outputs hold, no new descriptor accepted
    run_desc(0, 3, 21, lat);
    for (int c = 0; c < 5; c++) begin
      expect_res("t6", 21, 4, 6, 100, 14, 200, 3000, 1'b0);
      chk("t6.desc_ready", 64'(desc_ready), 64'd0);
      @(posedge Clk); #1;
    end
    consume("t6");

    // Two queued descriptors back to back
    si_in = 0; ei_in = 3; id_in = 11; desc_valid = 1'b1;
    @(posedge Clk); #1;
    si_in = 4; ei_in = 5; id_in = 12;
    lat = 1;
    while (!res_valid && lat < 200) begin
      chk("t7.busy_ready", 64'(desc_ready), 64'd0);
      @(posedge Clk); #1; lat++;
    end
    chk("t7.latency1", 64'(lat), 64'd6);
    expect_res("t7a", 11, 4, 6, 100, 14, 200, 3000, 1'b0);
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
    chk("t7.bubble_ready", 64'(desc_ready), 64'd1);
    @(posedge Clk); #1;
    desc_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(posedge Clk); #1; lat++;
    end
    chk("t7.latency2", 64'(lat), 64'd4);
    expect_res("t7b", 12, 2, 1, 10, 1, 7, 58, 1'b0);
    consume("t7");

    // Reset in the middle of FETCH
    si_in = 0; ei_in = 3; id_in = 33; desc_valid = 1'b1;
    @(posedge Clk); #1;
    desc_valid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("t8.rd_en_mid", 64'(rd_en), 64'd1);
    chk("t8.sy_mid",    sum_y, 64'd10);
    Rst = 1'b0;
    #1;
    chk("t8.rd_en",      64'(rd_en), 64'd0);
    chk("t8.rd_addr",    64'(rd_addr), 64'd0);
    chk("t8.desc_ready", 64'(desc_ready), 64'd0);
    chk("t8.res_valid",  64'(res_valid), 64'd0);
    chk("t8.id_out",     64'(id_out), 64'd0);
    chk("t8.n_out",      64'(n_out), 64'd0);
    chk("t8.sum_x",      sum_x, 64'd0);
    chk("t8.sum_y",      sum_y, 64'd0);
    chk("t8.sum_xy",     sum_xy, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    addr_log.delete();
    run_desc(0, 3, 7, lat);
    chk("t9.latency", 64'(lat), 64'd6);
    expect_res("t9", 7, 4, 6, 100, 14, 200, 3000, 1'b0);
    chk("t9.nreads", 64'(addr_log.size()), 64'd4);
    consume("t9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
